// File: rtl/regfile_sb_if.sv
// Register file bus: writeback write port, two decode read ports with
// scoreboard bits, issue marking and the soft-clear request/status.
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              W_En;
    logic [ADDR_W-1:0] W_Addr;
    logic [DATA_W-1:0] W_Data;
    logic [ADDR_W-1:0] R_Addr_A;
    logic [DATA_W-1:0] R_Data_A;
    logic [ADDR_W-1:0] R_Addr_B;
    logic [DATA_W-1:0] R_Data_B;
    logic              Pend_A;
    logic              Pend_B;
    logic              Iss_En;
    logic [ADDR_W-1:0] Iss_Addr;
    logic              Clr_Req;
    logic              Busy;

    // Pipeline side: decode/writeback drive requests, observe read data.
    modport master (
        output W_En, W_Addr, W_Data,
        output R_Addr_A, R_Addr_B,
        output Iss_En, Iss_Addr,
        output Clr_Req,
        input  R_Data_A, R_Data_B, Pend_A, Pend_B, Busy
    );

    // Register file side.
    modport slave (
        input  W_En, W_Addr, W_Data,
        input  R_Addr_A, R_Addr_B,
        input  Iss_En, Iss_Addr,
        input  Clr_Req,
        output R_Data_A, R_Data_B, Pend_A, Pend_B, Busy
    );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with pending-write scoreboard and a
// multi-cycle soft-clear sweep (one register per cycle).
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding in IDLE.
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;

    logic              idle;
    logic              wr_ok;
    logic              iss_ok;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              pd_a, pd_b;

    assign idle = (state_q == StIdle);

    // Register 0 is hardwired when ZERO_REG is set: no writes, never pending.
    assign wr_ok  = idle && bus.W_En && !(ZERO_REG && (bus.W_Addr == '0));
    assign iss_ok = idle && bus.Iss_En && !(ZERO_REG && (bus.Iss_Addr == '0));

    // Next-state: writes/issue in IDLE, one-register-per-cycle sweep in CLEAR.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        pend_d  = pend_q;
        unique case (state_q)
            StIdle: begin
                if (wr_ok) begin
                    regs_d[bus.W_Addr] = bus.W_Data;
                    pend_d[bus.W_Addr] = 1'b0;
                end
                // Applied after the write so a new producer supersedes the retiring one.
                if (iss_ok) begin
                    pend_d[bus.Iss_Addr] = 1'b1;
                end
                if (bus.Clr_Req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                regs_d[cnt_q] = '0;
                pend_d[cnt_q] = 1'b0;
                if (cnt_q == LAST_IDX) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, array and scoreboard registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port A: stored contents, optionally forwarded from the write port.
    always_comb begin
        rd_a = regs_q[bus.R_Addr_A];
        pd_a = pend_q[bus.R_Addr_A];
        if (ZERO_REG && (bus.R_Addr_A == '0)) begin
            rd_a = '0;
            pd_a = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (bus.W_Addr == bus.R_Addr_A)) begin
            rd_a = bus.W_Data;
            // A same-cycle issue to this register keeps the stored bit visible.
            if (!(bus.Iss_En && (bus.Iss_Addr == bus.R_Addr_A))) begin
                pd_a = 1'b0;
            end
        end
`endif
    end

    // Read port B: same as port A.
    always_comb begin
        rd_b = regs_q[bus.R_Addr_B];
        pd_b = pend_q[bus.R_Addr_B];
        if (ZERO_REG && (bus.R_Addr_B == '0)) begin
            rd_b = '0;
            pd_b = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (bus.W_Addr == bus.R_Addr_B)) begin
            rd_b = bus.W_Data;
            if (!(bus.Iss_En && (bus.Iss_Addr == bus.R_Addr_B))) begin
                pd_b = 1'b0;
            end
        end
`endif
    end

    assign bus.R_Data_A = rd_a;
    assign bus.R_Data_B = rd_b;
    assign bus.Pend_A   = pd_a;
    assign bus.Pend_B   = pd_b;
    assign bus.Busy     = (state_q == StClear);

endmodule
